dc_motor_hbridge: RTL and testbench
===================================

# dc_motor_hbridge

Parametrised successor of the single-channel DC motor driver: generates a PWM H-bridge drive (two half-bridges, each with a high-side command and an enable) from a duty value and a direction request. It adds configurable PWM resolution, dead time on direction reversal, period-aligned shadowing of duty and direction, and a latched overcurrent trip with timed lockout. A current-sense ADC strobe is aligned mid on-time. The block sits between the motion-control register file and the bridge pins / ADC sequencer.

## Interface
- PWM_W, 12: duty/counter width; PWM period = 2^PWM_W-1 clk cycles
- ADC_W, 12: width of adc and adc_cmp
- DEAD_CYC, 8: cycles both enables are low on direction change
- ADC_LAT, 2: cycles from adc_latch pulse until adc holds the new sample
- TRIP_HOLD, 1024: lockout cycles after overcurrent
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  drive enable; low forces IDLE
- cw / ccw  in  1 / 1  direction request
- value  in  PWM_W  duty; on-cycles per period
- adc_cmp  in  ADC_W  overcurrent threshold
- adc  in  ADC_W  current-sense sample
- out_1 / out_2  out  1 / 1  high-side command, half-bridge 1/2
- en_1 / en_2  out  1 / 1  half-bridge enables (low = tri-state/coast)
- adc_latch  out  1  one-cycle ADC sample strobe
- fault  out  1  high while in TRIP

## Operation
- Counter cnt runs 0..2^PWM_W-2, wraps to 0; runs in every state.
- At cnt==0: value → duty_sh, requested direction → dir_sh. Mid-period changes take effect next period.
- pwm = (cnt < duty_sh). value 0: never on; value 2^PWM_W-1: always on.
- Direction decode: cw&!ccw → CW; ccw&!cw → CCW; both → BRAKE; neither → COAST.
- CW: out_1=pwm, out_2=0, en=11. CCW: out_1=0, out_2=pwm, en=11. COAST: out=00, en=00. BRAKE: see Configuration.
- States: IDLE (out/en 0), RUN, DEAD, TRIP.
- IDLE→RUN at cnt==0 with enable high.
- RUN→DEAD when dir_sh changes between CW and CCW (either way); DEAD holds out/en 0 for DEAD_CYC cycles, then RUN with new direction. Changes to/from COAST/BRAKE skip DEAD.
- adc_latch pulses when duty_sh≥2, dir_sh is CW/CCW, state RUN and cnt==duty_sh>>1; no pulse otherwise.
- ADC_LAT cycles after the pulse: adc > adc_cmp (unsigned) → TRIP next cycle; adc == adc_cmp does not trip.
- TRIP: out/en 0, fault=1, counts TRIP_HOLD cycles, then IDLE (fault clears); re-entry to RUN at next cnt==0 with enable.
- enable low in any state → IDLE next cycle, except TRIP, which completes its hold.
- Pending compare is discarded if state leaves RUN before it is evaluated.

## Timing
- Reset: cnt=0, state IDLE, duty_sh=0, dir_sh=COAST; out_1, out_2, en_1, en_2, adc_latch, fault all 0.
- All outputs registered; pin change occurs 1 cycle after the cnt/state condition.
- First on-edge: enable rising → RUN at next cnt==0 → out high 1 cycle later.
- Trip response: ≤ ADC_LAT+2 cycles from adc_latch to en_1/en_2 low.
- Simultaneous enable-low and trip compare: TRIP wins.
- Reset mid-period or mid-TRIP: immediate return to reset values.

## Configuration
- DC_MOTOR_BRAKE_EN defined: BRAKE drives out=00, en=11 (both low sides on, active short-circuit brake).
- Undefined: BRAKE is treated as COAST (out=00, en=00).

## Structure
- Package dc_motor_pkg: state enum (IDLE, RUN, DEAD, TRIP), direction enum (COAST, CW, CCW, BRAKE), direction-decode function.
- Sub-module dc_motor_pwm_gen: counter, shadow registers, pwm compare, adc_latch timing. FSM, dead time, trip logic in top.

## Test plan
- PWM_W=12, value=500, cw=1, adc=0: out_1 high 500 of 4095 cycles, out_2=0, en=11; adc_latch at cnt==250.
- value 500→2000 at cnt==1000: current period keeps 500; next period 2000.
- cw→ccw in RUN: en=00 for exactly 8 cycles, then out_2 PWM; out_1 and out_2 never high together.
- adc_cmp=3000, adc=4000 at sample: en low ≤4 cycles after adc_latch, fault=1 for 1024 cycles, restart at next cnt==0; adc=3000 gives no trip.
- cw=ccw=1: en=11/out=00 with DC_MOTOR_BRAKE_EN, en=00 without.
- value=0 and value=4095: no adc_latch / out_1 constantly high; reset mid-TRIP clears fault immediately.

Source files
------------

// File: rtl/dc_motor_pkg.sv
// dc_motor_pkg: shared FSM/direction types and the direction-request decode for the H-bridge driver.
package dc_motor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2, TRIP = 2'd3} state_t;
    typedef enum logic [1:0] {COAST = 2'b00, CW = 2'b01, CCW = 2'b10, BRAKE = 2'b11} dir_t;
    function automatic dir_t dir_decode(input logic cw, input logic ccw);
        return (cw && ccw) ? BRAKE : cw ? CW : ccw ? CCW : COAST;
    endfunction
    function automatic logic is_drive(input logic [1:0] d);
        return d == CW || d == CCW;
    endfunction
endpackage

// File: rtl/dc_motor_pwm_gen.sv
// dc_motor_pwm_gen: free-running PWM counter, period-aligned duty/direction shadows and mid-on-time ADC strobe.
module dc_motor_pwm_gen
    import dc_motor_pkg::*;
#(
    parameter int PWM_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cw,
    input  logic             ccw,
    input  logic [PWM_W-1:0] value,
    output logic             cnt_zero,
    output logic [1:0]       dir,
    output logic [1:0]       dir_prev,
    output logic             pwm,
    output logic             adc_latch
);
    localparam logic [PWM_W-1:0] CNT_MAX = {{(PWM_W-1){1'b1}}, 1'b0};
    logic [PWM_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
    dir_t dir_q, dir_d;
    logic adc_latch_q, adc_latch_d;
    // Shadows are transparent at cnt==0 so a new period's settings apply from its first cycle.
    always_comb begin
        cnt_zero = cnt_q == '0;
        cnt_d    = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
        duty_d   = cnt_zero ? value : duty_q;
        dir_d    = cnt_zero ? dir_decode(cw, ccw) : dir_q;
        pwm      = cnt_q < duty_d;
    end
    assign adc_latch_d = run && is_drive(dir_d) && (|duty_d[PWM_W-1:1]) && (cnt_q == (duty_d >> 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            duty_q      <= '0;
            dir_q       <= COAST;
            adc_latch_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            adc_latch_q <= adc_latch_d;
        end
    end
    assign dir       = dir_d;
    assign dir_prev  = dir_q;
    assign adc_latch = adc_latch_q;
endmodule

// File: rtl/dc_motor_hbridge.sv
// dc_motor_hbridge: PWM H-bridge driver with reversal dead time, shadowed settings and latched overcurrent trip.
// Define DC_MOTOR_BRAKE_EN to turn both low sides on for a brake request instead of coasting.
module dc_motor_hbridge
    import dc_motor_pkg::*;
#(
    parameter int PWM_W     = 12,
    parameter int ADC_W     = 12,
    parameter int DEAD_CYC  = 8,
    parameter int ADC_LAT   = 2,
    parameter int TRIP_HOLD = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cw,
    input  logic             ccw,
    input  logic [PWM_W-1:0] value,
    input  logic [ADC_W-1:0] adc_cmp,
    input  logic [ADC_W-1:0] adc,
    output logic             out_1,
    output logic             out_2,
    output logic             en_1,
    output logic             en_2,
    output logic             adc_latch,
    output logic             fault
);
    localparam int TW = $clog2((TRIP_HOLD > DEAD_CYC ? TRIP_HOLD : DEAD_CYC) + 1);
`ifdef DC_MOTOR_BRAKE_EN
    localparam logic BRAKE_DRIVE = 1'b1;
`else
    localparam logic BRAKE_DRIVE = 1'b0;
`endif
    state_t state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [ADC_LAT-1:0] pend_q, pend_d;
    logic out_1_q, out_1_d, out_2_q, out_2_d, en_q, en_d, fault_q, fault_d;
    logic cnt_zero, pwm, run, trip, reverse;
    logic [1:0] dir, dir_prev;
    dc_motor_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cw        (cw),
        .ccw       (ccw),
        .value     (value),
        .cnt_zero  (cnt_zero),
        .dir       (dir),
        .dir_prev  (dir_prev),
        .pwm       (pwm),
        .adc_latch (adc_latch)
    );
    // A sample in flight is only honoured while the bridge stays in RUN.
    always_comb begin
        trip    = state_q == RUN && pend_q[ADC_LAT-1] && adc > adc_cmp;
        reverse = is_drive(dir) && is_drive(dir_prev) && dir != dir_prev;
        pend_d  = state_q == RUN ? ((pend_q << 1) | ADC_LAT'(adc_latch)) : '0;
        tmr_d   = tmr_q == '0 ? '0 : tmr_q - 1'b1;
        state_d = state_q;
        case (state_q)
            IDLE: if (enable && cnt_zero) state_d = RUN;
            RUN: begin
                if (trip) begin
                    state_d = TRIP;
                    tmr_d   = TW'(TRIP_HOLD - 1);
                end else if (!enable) begin
                    state_d = IDLE;
                end else if (reverse) begin
                    state_d = DEAD;
                    tmr_d   = TW'(DEAD_CYC - 1);
                end
            end
            DEAD: state_d = !enable ? IDLE : tmr_q == '0 ? RUN : DEAD;
            TRIP: if (tmr_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign run = state_d == RUN;
    always_comb begin
        out_1_d = run && dir == CW && pwm;
        out_2_d = run && dir == CCW && pwm;
        en_d    = run && (is_drive(dir) || (BRAKE_DRIVE && dir == BRAKE));
        fault_d = state_d == TRIP;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            pend_q  <= '0;
            out_1_q <= 1'b0;
            out_2_q <= 1'b0;
            en_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            out_1_q <= out_1_d;
            out_2_q <= out_2_d;
            en_q    <= en_d;
            fault_q <= fault_d;
        end
    end
    assign out_1 = out_1_q;
    assign out_2 = out_2_q;
    assign en_1  = en_q;
    assign en_2  = en_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_dc_motor_hbridge.sv
// tb_dc_motor_hbridge: directed and randomized stimulus against a timestamp-based reference model feeding a pin scoreboard.
module tb_dc_motor_hbridge;
    localparam int PWM_W = 6, ADC_W = 8, DEAD_CYC = 8, ADC_LAT = 2, TRIP_HOLD = 150;
    localparam int P = 2**PWM_W - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_TRIP = 3;
`ifdef DC_MOTOR_BRAKE_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, enable, cw, ccw;
    logic [PWM_W-1:0] value;
    logic [ADC_W-1:0] adc_cmp, adc;
    logic out_1, out_2, en_1, en_2, adc_latch, fault;
    int checks = 0, passed = 0, latch_seen = 0, fault_seen = 0;
    int n = 0, m_cnt, m_duty, m_dir, m_mode, m_dead_end, m_trip_end;
    int evals[$];
    logic [5:0] exp_q[$];

    dc_motor_hbridge #(
        .PWM_W(PWM_W), .ADC_W(ADC_W), .DEAD_CYC(DEAD_CYC), .ADC_LAT(ADC_LAT), .TRIP_HOLD(TRIP_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cw(cw), .ccw(ccw), .value(value),
        .adc_cmp(adc_cmp), .adc(adc), .out_1(out_1), .out_2(out_2), .en_1(en_1), .en_2(en_2),
        .adc_latch(adc_latch), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
    endtask

    function automatic int decode(input logic a_cw, input logic a_ccw);
        return (a_cw && a_ccw) ? 3 : a_cw ? 1 : a_ccw ? 2 : 0;
    endfunction

    // Reference: given this cycle's inputs, predict the pins seen after the next rising edge.
    task automatic model_step();
        int duty, dir, nmode;
        bit zero, trip, run, drive, en, latch;
        if (reset) begin
            m_cnt = 0; m_duty = 0; m_dir = 0; m_mode = M_IDLE;
            evals.delete();
            exp_q.push_back('0);
            n++;
            return;
        end
        zero = m_cnt == 0;
        duty = zero ? int'(value) : m_duty;
        dir  = zero ? decode(cw, ccw) : m_dir;
        if (m_mode != M_RUN) evals.delete();
        trip = 1'b0;
        while (evals.size() > 0 && evals[0] <= n) begin
            if (evals[0] == n && adc > adc_cmp) trip = 1'b1;
            void'(evals.pop_front());
        end
        nmode = m_mode;
        case (m_mode)
            M_IDLE: if (enable && zero) nmode = M_RUN;
            M_RUN: begin
                if (trip) begin nmode = M_TRIP; m_trip_end = n + TRIP_HOLD; end
                else if (!enable) nmode = M_IDLE;
                else if ((dir == 1 && m_dir == 2) || (dir == 2 && m_dir == 1)) begin
                    nmode = M_DEAD; m_dead_end = n + DEAD_CYC;
                end
            end
            M_DEAD: if (!enable) nmode = M_IDLE; else if (n >= m_dead_end) nmode = M_RUN;
            default: if (n >= m_trip_end) nmode = M_IDLE;
        endcase
        run   = nmode == M_RUN;
        drive = dir == 1 || dir == 2;
        en    = run && (drive || (BRK && dir == 3));
        latch = run && drive && duty >= 2 && m_cnt == duty / 2;
        exp_q.push_back({run && dir == 1 && m_cnt < duty, run && dir == 2 && m_cnt < duty, en, en, latch, nmode == M_TRIP});
        if (latch) evals.push_back(n + 1 + ADC_LAT);
        m_cnt = (m_cnt + 1) % P; m_duty = duty; m_dir = dir; m_mode = nmode;
        n++;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 2 * P && m_cnt != c; i++) cyc();
    endtask

    task automatic wait_mode(input int md, input int budget);
        for (int i = 0; i < budget && m_mode != md; i++) cyc();
    endtask

    // Asynchronous reset clears the pins within the current cycle, replacing its pending expectation.
    task automatic assert_reset();
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    initial begin
        logic [5:0] want;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
            end else begin
                want = exp_q.pop_front();
                check("pins{o1,o2,e1,e2,latch,fault}", {out_1, out_2, en_1, en_2, adc_latch, fault}, want);
            end
            check("shoot_through", {5'b0, out_1 & out_2}, 6'b0);
            if (adc_latch) latch_seen++;
            if (fault) fault_seen++;
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; cw = 1'b1; ccw = 1'b0;
        value = PWM_W'(20); adc_cmp = ADC_W'(200); adc = '0;
        cycles(3);
        reset = 1'b0;
        cycles(3 * P);
        wait_cnt(30); value = PWM_W'(40); cycles(2 * P);
        cw = 1'b0; ccw = 1'b1; cycles(2 * P);
        cw = 1'b1; ccw = 1'b0; cycles(2 * P);
        value = '0; cycles(2 * P);
        value = PWM_W'(P); cycles(2 * P);
        value = PWM_W'(30); adc = adc_cmp; cycles(2 * P);
        adc = adc_cmp + 1'b1;
        wait_mode(M_TRIP, 4 * P);
        enable = 1'b0; cycles(20); enable = 1'b1;
        cycles(TRIP_HOLD + 2 * P);
        wait_mode(M_TRIP, 4 * P);
        cycles(20);
        assert_reset(); adc = '0; cycles(2);
        reset = 1'b0; cycles(2 * P);
        cw = 1'b1; ccw = 1'b1; cycles(2 * P);
        cw = 1'b0; ccw = 1'b0; cycles(P);
        cw = 1'b1; cycles(P + 17);
        enable = 1'b0; cycles(5); enable = 1'b1; cycles(2 * P);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199) == 0) enable = ~enable;
            if ($urandom_range(99) == 0) {cw, ccw} = 2'($urandom_range(3));
            if ($urandom_range(49) == 0)
                case ($urandom_range(5))
                    0: value = '0;
                    1: value = PWM_W'(P);
                    2: value = PWM_W'(1);
                    3: value = PWM_W'(2);
                    default: value = PWM_W'($urandom_range(P));
                endcase
            if ($urandom_range(499) == 0) adc_cmp = ADC_W'($urandom_range(254, 1));
            case ($urandom_range(15))
                0: adc = adc_cmp + 1'b1;
                1: adc = adc_cmp;
                default: adc = ADC_W'($urandom_range(int'(adc_cmp) - 1));
            endcase
            if ($urandom_range(2999) == 0) begin
                assert_reset(); cyc(); reset = 1'b0;
            end
            cyc();
        end
        @(negedge clk); #1;
        check("adc_latch_observed", {5'b0, latch_seen > 0}, 6'b1);
        check("fault_observed", {5'b0, fault_seen >= TRIP_HOLD}, 6'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
